// File: rtl/pico_io_bridge.sv
// rtl/pico_io_bridge.sv - PacoBlaze port fabric: input mux, output regs, phoneme queue, irq pending
module pico_io_bridge #(
  parameter int         NUM_IN       = 4,
  parameter int         NUM_OUT      = 4,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] PHONEME_PORT = 8'h80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           port_id,
  input  logic [7:0]           out_port,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  output logic [7:0]           in_port,
  output logic                 interrupt,
  input  logic [8*NUM_IN-1:0]  input_data,
  input  logic [NUM_IN-1:0]    irq_src,
  output logic [8*NUM_OUT-1:0] output_data,
  output logic [7:0]           phoneme_select,
  output logic                 phoneme_valid,
  input  logic                 phoneme_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]               in_port_q, in_port_d;
  logic                     interrupt_q, interrupt_d;
  logic [NUM_OUT-1:0][7:0]  out_q, out_d;
  logic [NUM_IN-1:0]        mask_q, mask_d;
  logic [NUM_IN-1:0]        pending_q, pending_d;
  logic [NUM_IN-1:0]        prev_q, prev_d;
  logic                     overflow_q, overflow_d;
  logic [CW-1:0]            count_q, count_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [7:0]               mem_q [FIFO_DEPTH];
  logic [7:0]               mem_d [FIFO_DEPTH];

  logic full, empty, push, pop, accept, rd_status, rd_pending;
  logic [NUM_IN-1:0] clr;

  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    empty      = (count_q == '0);
    push       = write_strobe && (port_id == PHONEME_PORT);
    pop        = !empty && phoneme_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    accept     = push && (!full || pop);
    rd_status  = read_strobe && (port_id == 8'h10);
    rd_pending = read_strobe && (port_id == 8'h11);

    in_port_d = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (port_id == 8'(i)) in_port_d = input_data[8*i +: 8];
    end
    if (port_id == 8'h10) in_port_d = {full, empty, overflow_q, 5'(count_q)};
    if (port_id == 8'h11) in_port_d = 8'(pending_q);

    count_d  = count_q + CW'(accept) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(accept);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] = mem_q[i];
    if (accept) mem_d[wr_ptr_q] = out_port;

    overflow_d = overflow_q;
    if (rd_status) overflow_d = 1'b0;
    if (push && full && !pop) overflow_d = 1'b1;

    // Only bits visible in the returned byte are acknowledged; fresh edges survive.
    clr         = rd_pending ? (pending_q & NUM_IN'(8'hFF)) : '0;
    pending_d   = (pending_q & ~clr) | (irq_src & ~prev_q);
    prev_d      = irq_src;
    interrupt_d = |(pending_q & mask_q);

    out_d  = out_q;
    mask_d = mask_q;
    if (write_strobe) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (port_id == 8'(i)) out_d[i] = out_port;
      end
      if (port_id == 8'h20) mask_d = NUM_IN'(out_port);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_port_q   <= 8'h00;
      interrupt_q <= 1'b0;
      out_q       <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      prev_q      <= irq_src;
      overflow_q  <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      in_port_q   <= in_port_d;
      interrupt_q <= interrupt_d;
      out_q       <= out_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      prev_q      <= prev_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign in_port        = in_port_q;
  assign interrupt      = interrupt_q;
  assign output_data    = out_q;
  assign phoneme_valid  = !empty;
  assign phoneme_select = empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule
